// File: rtl/muldiv_e.sv
// muldiv_e: EX-stage HI/LO unit with a fixed-latency multiplier, a restoring divider and MTHI/MTLO writes
module muldiv_e #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_e,
    input  logic [2:0]  op_e,
    input  logic [31:0] a_e,
    input  logic [31:0] b_e,
    input  logic        advance_e,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [5:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] x, y, rem, a_mag, b_mag;
    logic [32:0] trial;
    logic [63:0] prod;
    logic        neg_q, neg_r, accept, sx, sy;
    assign accept = state == IDLE && start_e && !op_e[2] && !flush;
    assign busy   = !reset && !flush && (state == RUN || accept);
    assign a_mag  = (op_e == 3'd2 && a_e[31]) ? -a_e : a_e;
    assign b_mag  = (op_e == 3'd2 && b_e[31]) ? -b_e : b_e;
    // x shifts out dividend bits on the left and collects quotient bits on the right
    assign trial  = {rem, x[31]} - {1'b0, y};
    assign sx     = !op_q[0] && x[31];
    assign sy     = !op_q[0] && y[31];
    assign prod   = {{32{sx}}, x} * {{32{sy}}, y};
    always_comb begin
        state_nx = state;
        if (flush) state_nx = IDLE;
        else if (state == IDLE) state_nx = accept ? RUN : IDLE;
        else if (state == RUN) state_nx = (cnt == 6'd0) ? DONE : RUN;
        else state_nx = advance_e ? IDLE : DONE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            x     <= '0;
            y     <= '0;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q  <= op_e[1:0];
                x     <= op_e[1] ? a_mag : a_e;
                y     <= op_e[1] ? b_mag : b_e;
                rem   <= '0;
                neg_q <= op_e == 3'd2 && (a_e[31] ^ b_e[31]);
                neg_r <= op_e == 3'd2 && a_e[31];
                cnt   <= op_e[1] ? 6'd32 : 6'(MUL_CYCLES - 1);
            end else if (state == RUN && !flush) begin
                if (cnt != 6'd0) begin
                    cnt <= cnt - 6'd1;
                    if (op_q[1]) begin
                        rem <= trial[32] ? {rem[30:0], x[31]} : trial[31:0];
                        x   <= {x[30:0], !trial[32]};
                    end
                end else if (!op_q[1]) begin
                    hi <= prod[63:32];
                    lo <= prod[31:0];
                end else if (y != 32'd0) begin
                    hi <= neg_r ? -rem : rem;
                    lo <= neg_q ? -x : x;
                end
            end
            if (state == IDLE && start_e && advance_e && !flush && op_e == 3'd4) hi <= a_e;
            if (state == IDLE && start_e && advance_e && !flush && op_e == 3'd5) lo <= a_e;
        end
    end
endmodule

// File: tb/tb_muldiv_e.sv
// tb_muldiv_e: directed and randomized checks of muldiv_e against a plain-arithmetic HI/LO model
module tb_muldiv_e;
    localparam int MC = 4;
    logic        clk = 0, reset = 1, start_e = 0, advance_e = 1, flush = 0;
    logic [2:0]  op_e = 0;
    logic [31:0] a_e = 0, b_e = 0;
    logic        busy;
    logic [31:0] hi, lo;
    int n_cmp = 0, n_bad = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    muldiv_e #(.MUL_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .start_e(start_e), .op_e(op_e), .a_e(a_e), .b_e(b_e),
        .advance_e(advance_e), .flush(flush), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] cur);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint q, r;
        logic [63:0] ua = {32'd0, a};
        logic [63:0] ub = {32'd0, b};
        if (op == 3'd0) return sa * sb;
        if (op == 3'd1) return ua * ub;
        if (op > 3'd3 || b == 32'd0) return cur;
        if (op == 3'd3) return {a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int exp_busy(input logic [2:0] op);
        return op < 3'd2 ? MC + 1 : 34;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n, output logic [31:0] rh, output logic [31:0] rl);
        start_e = 1; op_e = op; a_e = a; b_e = b; advance_e = 1; n = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (!busy) break;
            n++;
            @(negedge clk);
        end
        start_e = 0; rh = hi; rl = lo;
        @(negedge clk);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v, input logic adv);
        start_e = 1; op_e = op; a_e = v; advance_e = adv;
        @(negedge clk);
        start_e = 0; advance_e = 1;
    endtask

    task automatic test_reset;
        start_e = 1; op_e = 0; #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo); end
        @(negedge clk); start_e = 0; reset = 0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [2:0]  ops[5] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2};
        logic [31:0] as[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000};
        logic [31:0] bs[5]  = '{32'd2, 32'd5, 32'd2, 32'd7, 32'hFFFFFFFF};
        logic [31:0] eh[5]  = '{32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0};
        logic [31:0] el[5]  = '{32'hFFFFFFFE, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'd14, 32'h80000000};
        int n; logic [31:0] rh, rl;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], n, rh, rl);
            m_hi = eh[i]; m_lo = el[i];
            n_cmp++; if (n !== exp_busy(ops[i])) begin n_bad++; $display("FAIL dir%0d_busy got %0d want %0d", i, n, exp_busy(ops[i])); end
            n_cmp++; if (rh !== eh[i]) begin n_bad++; $display("FAIL dir%0d_hi got %h want %h", i, rh, eh[i]); end
            n_cmp++; if (rl !== el[i]) begin n_bad++; $display("FAIL dir%0d_lo got %h want %h", i, rl, el[i]); end
        end
    endtask

    task automatic test_mt_div_zero;
        int n; logic [31:0] rh, rl;
        start_e = 1; op_e = 3'd4; a_e = 32'h11; advance_e = 1; #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mthi_busy got %b want 0", busy); end
        @(negedge clk); start_e = 0;
        mt(3'd5, 32'h22, 1'b1);
        m_hi = 32'h11; m_lo = 32'h22;
        n_cmp++; if (hi !== 32'h11) begin n_bad++; $display("FAIL mthi got %h want 11", hi); end
        n_cmp++; if (lo !== 32'h22) begin n_bad++; $display("FAIL mtlo got %h want 22", lo); end
        run_op(3'd3, 32'd5, 32'd0, n, rh, rl);
        n_cmp++; if (n !== 34) begin n_bad++; $display("FAIL divz_busy got %0d want 34", n); end
        n_cmp++; if (rh !== 32'h11) begin n_bad++; $display("FAIL divz_hi got %h want 11", rh); end
        n_cmp++; if (rl !== 32'h22) begin n_bad++; $display("FAIL divz_lo got %h want 22", rl); end
    endtask

    task automatic test_flush;
        int n; logic [31:0] rh, rl;
        start_e = 1; op_e = 3'd2; a_e = 32'd1000; b_e = 32'd3; advance_e = 1;
        @(negedge clk); start_e = 0;
        repeat (9) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_pre_busy got %b want 1", busy); end
        flush = 1; #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %b want 0", busy); end
        @(negedge clk); flush = 0;
        n_cmp++; if ({hi, lo} !== {m_hi, m_lo}) begin n_bad++; $display("FAIL flush_hilo got %h want %h", {hi, lo}, {m_hi, m_lo}); end
        run_op(3'd1, 32'd3, 32'd4, n, rh, rl);
        m_hi = 0; m_lo = 12;
        n_cmp++; if (n !== MC + 1) begin n_bad++; $display("FAIL postflush_busy got %0d want %0d", n, MC + 1); end
        n_cmp++; if (rl !== 32'd12) begin n_bad++; $display("FAIL postflush_lo got %h want 0000000c", rl); end
    endtask

    task automatic test_done_hold;
        int n = 0;
        logic [31:0] a = $urandom, b = $urandom;
        logic [63:0] e = model(3'd0, a, b, {m_hi, m_lo});
        start_e = 1; op_e = 3'd0; a_e = a; b_e = b; advance_e = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (!busy) break;
            n++;
            @(negedge clk);
        end
        n_cmp++; if (n !== MC + 1) begin n_bad++; $display("FAIL hold_busycnt got %0d want %0d", n, MC + 1); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hold%0d_busy got %b want 0", i, busy); end
            n_cmp++; if ({hi, lo} !== e) begin n_bad++; $display("FAIL hold%0d_hilo got %h want %h", i, {hi, lo}, e); end
            @(negedge clk); #1;
        end
        {m_hi, m_lo} = e;
        advance_e = 1; start_e = 0;
        @(negedge clk);
        mt(3'd5, 32'hDEAD, 1'b0);
        #1;
        n_cmp++; if (lo !== m_lo) begin n_bad++; $display("FAIL mtlo_noadv got %h want %h", lo, m_lo); end
    endtask

    task automatic test_reset_mid;
        int n; logic [31:0] rh, rl;
        logic [31:0] a = $urandom, b = $urandom;
        logic [63:0] e;
        mt(3'd4, 32'h55, 1'b1);
        start_e = 1; op_e = 3'd2; a_e = 32'h12345; b_e = 32'd9; advance_e = 1;
        @(negedge clk); start_e = 0;
        repeat (19) @(negedge clk);
        reset = 1; #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_cmp++; if ({hi, lo} !== 64'd0) begin n_bad++; $display("FAIL rstmid_hilo got %h want 0", {hi, lo}); end
        @(negedge clk); reset = 0; m_hi = 0; m_lo = 0;
        @(negedge clk);
        e = model(3'd1, a, b, 64'd0);
        run_op(3'd1, a, b, n, rh, rl);
        {m_hi, m_lo} = e;
        n_cmp++; if (n !== MC + 1) begin n_bad++; $display("FAIL rstpost_busy got %0d want %0d", n, MC + 1); end
        n_cmp++; if ({rh, rl} !== e) begin n_bad++; $display("FAIL rstpost_hilo got %h want %h", {rh, rl}, e); end
    endtask

    task automatic test_back_to_back;
        int n; logic [31:0] rh, rl, a, b;
        logic [2:0] op;
        logic [63:0] e;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: b = -($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            e = model(op, a, b, {m_hi, m_lo});
            run_op(op, a, b, n, rh, rl);
            {m_hi, m_lo} = e;
            n_cmp++; if (n !== exp_busy(op)) begin n_bad++; $display("FAIL rnd%0d_busy op%0d got %0d want %0d", i, op, n, exp_busy(op)); end
            n_cmp++; if ({rh, rl} !== e) begin n_bad++; $display("FAIL rnd%0d_hilo op%0d a=%h b=%h got %h want %h", i, op, a, b, {rh, rl}, e); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_directed;
        test_mt_div_zero;
        test_flush;
        test_done_hold;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
